da_sequencer: RTL and testbench

Bit-serial sequencer for the distributed-arithmetic FIR subfilter. It accepts parallel two's-complement samples over a valid/ready handshake and serialises each one LSB-first onto the subfilter's `D` input. It generates the `shift_en`, `acc_en`, `SWb`, `Ts` and `SWa` controls, aligned to the subfilter's registered ROM latency, and flags the cycle in which the subfilter's `y` output holds a finished result.

---
 rtl/da_sequencer.sv | 123 ++++++++++++
 tb/tb_da_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/da_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | da_sequencer: bit-serial sample sequencer and control generator for the    |
// | distributed-arithmetic FIR subfilter.                 Revision: 1.0        |
// +----------------------------------------------------------------------------+
module da_sequencer #(
  parameter int word_width  = 16,
  parameter int rom_latency = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [word_width-1:0] in_data,
  output logic                  in_ready,
  output logic                  D,
  output logic                  shift_en,
  output logic                  acc_en,
  output logic                  SWb,
  output logic                  Ts,
  output logic                  SWa,
  output logic                  y_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_ovr
);

  localparam int CW = (word_width > 1) ? $clog2(word_width) : 1;
  localparam int DW = (rom_latency > 0) ? $clog2(rom_latency + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(word_width - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'((rom_latency > 0) ? rom_latency - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [word_width-1:0] samp_q, samp_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]         drn_q, drn_d;
  logic                  D_q, D_d;
  logic                  overrun_q, overrun_d;
  logic                  w_shift;
  // Control stage bundle {en, first, last}; stage 0 is the shift side,
  // stage rom_latency is aligned to the accumulator.
  logic [2:0]            ctl_d;
  logic [2:0]            pipe_q [0:rom_latency];

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_cnt_d = bit_cnt_q;
    drn_d     = drn_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SHIFT;
          samp_d    = in_data;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = (rom_latency == 0) ? IDLE : DRAIN;
          drn_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == LAST_DRN) state_d = IDLE;
        else                   drn_d   = drn_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so the registered
    // versions line up with the cycle the FSM is actually in.
    w_shift   = (state_d == SHIFT);
    D_d       = w_shift & samp_d[bit_cnt_d];
    ctl_d     = {w_shift, w_shift && (bit_cnt_d == '0), w_shift && (bit_cnt_d == LAST_BIT)};

    // A set in the same cycle as a clear wins.
    if (in_valid && (state_q != IDLE)) overrun_d = 1'b1;
    else if (clr_ovr)                  overrun_d = 1'b0;
    else                               overrun_d = overrun_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      samp_q    <= '0;
      bit_cnt_q <= '0;
      drn_q     <= '0;
      D_q       <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i <= rom_latency; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_cnt_q <= bit_cnt_d;
      drn_q     <= drn_d;
      D_q       <= D_d;
      overrun_q <= overrun_d;
      pipe_q[0] <= ctl_d;
      for (int i = 1; i <= rom_latency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = !in_ready;
  assign D        = D_q;
  assign shift_en = pipe_q[0][2];
  assign acc_en   = pipe_q[rom_latency][2];
  assign SWb      = pipe_q[rom_latency][1];
  assign Ts       = pipe_q[rom_latency][0];
  assign SWa      = pipe_q[rom_latency][0];
  assign y_valid  = pipe_q[rom_latency][0];
  assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_da_sequencer.sv
`default_nettype none
// Bench for da_sequencer: four instances (W/L = 16/1, 16/0, 16/3, 1/2) share
// stimulus and are checked against a cycle-offset reference model.
module tb_da_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        clr_ovr;
  logic [15:0] in_data;
  logic [9:0]  act [4];

  always #5 clk = ~clk;

  // act bit order: {in_ready, busy, D, shift_en, acc_en, SWb, Ts, SWa, y_valid, overrun}
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int WP = (g == 3) ? 1 : 16;
      localparam int LP = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 2;
      logic rdy, bsy, d, se, ae, swb, ts, swa, yv, ov;
      da_sequencer #(.word_width(WP), .rom_latency(LP)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[WP-1:0]),
        .in_ready(rdy), .D(d), .shift_en(se), .acc_en(ae), .SWb(swb), .Ts(ts),
        .SWa(swa), .y_valid(yv), .busy(bsy), .overrun(ov), .clr_ovr(clr_ovr));
      assign act[g] = {rdy, bsy, d, se, ae, swb, ts, swa, yv, ov};
    end
  endgenerate

  int          Wm [4] = '{16, 16, 16, 1};
  int          Lm [4] = '{1, 0, 3, 2};
  int          k    [4];   // cycles since accept, 0 = idle
  logic [15:0] samp [4];
  bit          ovr  [4];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  typedef struct {
    bit          v;
    logic [15:0] data;
    bit          rdy, d, se, ae, swb, swa;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [9:0] model_out(int i);
    int   kk = k[i];
    int   w  = Wm[i];
    int   l  = Lm[i];
    logic b, d, se, ae, swb, fin;
    b   = (kk >= 1) && (kk <= w + l);
    se  = (kk >= 1) && (kk <= w);
    d   = se ? samp[i][kk-1] : 1'b0;
    ae  = (kk >= 1 + l) && (kk <= w + l);
    swb = (kk == 1 + l);
    fin = (kk == w + l);
    return {!b, b, d, se, ae, swb, fin, fin, fin, ovr[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      k[i] = 0; ovr[i] = 1'b0; samp[i] = '0;
    end
  endtask

  task automatic cmp(string name, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc%0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic check_all(string name);
    logic [9:0] e;
    for (int i = 0; i < 4; i++) begin
      e = model_out(i);
      vectors++;
      if (act[i] !== e) begin
        miscompares++;
        $display("FAIL %s inst%0d cyc%0d: got %b expected %b", name, i, cyc, act[i], e);
      end
    end
  endtask

  task automatic step(string name);
    bit          pv = in_valid;
    bit          pc = clr_ovr;
    logic [15:0] pd = in_data;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (pv && (k[i] != 0)) ovr[i] = 1'b1;
        else if (pc)           ovr[i] = 1'b0;
        if (k[i] == 0) begin
          if (pv) begin k[i] = 1; samp[i] = pd; end
        end else begin
          k[i]++;
          if (k[i] > Wm[i] + Lm[i]) k[i] = 0;
        end
      end
    end
    cyc++;
    #1;
    check_all(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rdy [4];
    int acc_t [$];
    int yv_cnt;
    int n;
    bit ok;

    // 16'hA5C3 through the W=16, L=1 instance: cycle j+1 after accept per row
    tbl[0]  = '{1'b1, 16'hA5C3, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{1'b0, 16'h0000, 0, 1, 1, 1, 1, 0};
    tbl[2]  = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[3]  = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{1'b0, 16'h0000, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{1'b0, 16'h0000, 0, 1, 1, 1, 0, 0};
    tbl[8]  = '{1'b0, 16'h0000, 0, 1, 1, 1, 0, 0};
    tbl[9]  = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{1'b0, 16'h0000, 0, 1, 1, 1, 0, 0};
    tbl[11] = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[13] = '{1'b0, 16'h0000, 0, 1, 1, 1, 0, 0};
    tbl[14] = '{1'b0, 16'h0000, 0, 0, 1, 1, 0, 0};
    tbl[15] = '{1'b0, 16'h0000, 0, 1, 1, 1, 0, 0};
    tbl[16] = '{1'b0, 16'h0000, 0, 0, 0, 1, 0, 1};
    tbl[17] = '{1'b0, 16'h0000, 1, 0, 0, 0, 0, 0};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; clr_ovr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    repeat (2) step("idle");

    // Single sample, table driven
    for (int j = 0; j < 18; j++) begin
      in_valid = tbl[j].v;
      in_data  = tbl[j].data;
      step("single");
      cmp("tbl_ready", int'(act[0][9]), int'(tbl[j].rdy));
      cmp("tbl_D",     int'(act[0][7]), int'(tbl[j].d));
      cmp("tbl_shift", int'(act[0][6]), int'(tbl[j].se));
      cmp("tbl_acc",   int'(act[0][5]), int'(tbl[j].ae));
      cmp("tbl_SWb",   int'(act[0][4]), int'(tbl[j].swb));
      cmp("tbl_SWa",   int'(act[0][2]), int'(tbl[j].swa));
    end
    in_valid = 1'b0;
    repeat (8) step("drain");

    // Latency sweep: in_ready returns at W+L+1 for every instance
    in_valid = 1'b1; in_data = 16'h3C5A;
    step("sweep");
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) first_rdy[i] = 0;
    n = 1;
    while (n < 30) begin
      step("sweep");
      n++;
      for (int i = 0; i < 4; i++)
        if (first_rdy[i] == 0 && act[i][9]) first_rdy[i] = n;
    end
    for (int i = 0; i < 4; i++) cmp("ready_return", first_rdy[i], Wm[i] + Lm[i] + 1);

    // Back-to-back with in_valid held
    in_valid = 1'b1; in_data = 16'h8001; yv_cnt = 0;
    for (int s = 0; s < 72; s++) begin
      if (act[0][9]) acc_t.push_back(s);
      step("b2b");
      if (act[0][1]) yv_cnt++;
    end
    in_valid = 1'b0;
    cmp("b2b_overrun", int'(act[0][0]), 1);
    for (int s = 0; s < 20; s++) begin
      step("b2b_tail");
      if (act[0][1]) yv_cnt++;
    end
    cmp("b2b_accepts", acc_t.size(), 4);
    cmp("b2b_yvalid", yv_cnt, 4);
    for (int i = 1; i < acc_t.size(); i++) cmp("b2b_spacing", acc_t[i] - acc_t[i-1], 18);

    // Overrun clear while ready, then clear losing to a set while busy
    in_valid = 1'b1; in_data = 16'h1234;
    ok = 1'b0;
    for (int s = 0; s < 40 && !ok; s++) begin
      if (act[0][9]) ok = 1'b1;
      else step("ovr_wait");
    end
    cmp("ovr_wait_ready", int'(ok), 1);
    clr_ovr = 1'b1;
    step("ovr_clr");
    cmp("ovr_cleared", int'(act[0][0]), 0);
    step("ovr_set_wins");
    cmp("ovr_set_wins", int'(act[0][0]), 1);
    clr_ovr = 1'b0; in_valid = 1'b0;
    repeat (25) step("ovr_drain");

    // Asynchronous reset in cycle 7 of SHIFT
    in_valid = 1'b1; in_data = 16'hFFFF;
    step("mid_accept");
    in_valid = 1'b0;
    repeat (6) step("mid_shift");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    cmp("async_reset_main", int'(act[0]), int'(10'b10_0000_0000));
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all("reset_release");
    in_valid = 1'b1; in_data = 16'h0F0F;
    step("post_reset");
    in_valid = 1'b0;
    repeat (22) step("post_reset");

    // Randomized traffic against the reference model
    for (int s = 0; s < 600; s++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 16'($urandom);
      clr_ovr  = ($urandom_range(0, 7) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
